psum_collector: RTL and testbench

//  Downstream stage of the 16-array PE cube. Captures one 16-lane result vector per valid strobe.
//  - Non-final tile: holds it as the partial sum fed back to the cube's psum-from-last-tile inputs.
//  - Final tile: serialises the 16 results, one lane per beat, on a valid/ready stream to the writeback path.

---
 rtl/psum_collector.sv | 134 +++++++++++++
 tb/tb_psum_collector.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/psum_collector.sv
`default_nettype none
// ---------------------------------------------------------------------------
// psum_collector: captures 16-lane cube results as psum feedback or drains them
// one lane per beat on a valid/ready stream. Optional: PSUM_COLLECTOR_RELU_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
module psum_collector #(
   parameter int LANES  = 16,
   parameter int DATA_W = 32,
   parameter int S1_W   = 21
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_clear,
   input  logic                      i_result_valid,
   input  logic                      i_last_tile,
   input  logic                      i_strategy_2_en,
   input  logic [LANES*S1_W-1:0]     i_result_s1,
   input  logic [LANES*DATA_W-1:0]   i_result_s2,
   output logic                      o_in_ready,
   output logic [LANES*DATA_W-1:0]   o_psum,
   output logic                      o_valid,
   output logic [DATA_W-1:0]         o_data,
   output logic [$clog2(LANES)-1:0]  o_lane,
   output logic                      o_last,
   input  logic                      i_ready,
   output logic                      o_drop
);

   localparam int LANE_W = $clog2(LANES);
   localparam logic [LANE_W-1:0] C_LAST_LANE = LANE_W'(LANES - 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   state_t                    state_q, state_d;
   logic [LANE_W-1:0]         lane_q, lane_d;
   logic [LANES*DATA_W-1:0]   psum_q, psum_d;
   logic [LANES*DATA_W-1:0]   outbuf_q, outbuf_d;
   logic                      drop_q, drop_d;

   logic [LANES*DATA_W-1:0]   w_sel;
   logic [LANES*DATA_W-1:0]   w_fin;
   logic [DATA_W-1:0]         w_out_lane [LANES];

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic [S1_W-1:0] w_s1;
      assign w_s1 = i_result_s1[k*S1_W +: S1_W];
      assign w_sel[k*DATA_W +: DATA_W] = i_strategy_2_en ? i_result_s2[k*DATA_W +: DATA_W]
                                       : {{(DATA_W-S1_W){w_s1[S1_W-1]}}, w_s1};
`ifdef PSUM_COLLECTOR_RELU_EN
      // ReLU applies only to the drained output, never to the psum feedback
      assign w_fin[k*DATA_W +: DATA_W] = w_sel[k*DATA_W + DATA_W - 1] ? '0
                                       : w_sel[k*DATA_W +: DATA_W];
`else
      assign w_fin[k*DATA_W +: DATA_W] = w_sel[k*DATA_W +: DATA_W];
`endif
      assign w_out_lane[k] = outbuf_q[k*DATA_W +: DATA_W];
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= IDLE;
         lane_q   <= '0;
         psum_q   <= '0;
         outbuf_q <= '0;
         drop_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         lane_q   <= lane_d;
         psum_q   <= psum_d;
         outbuf_q <= outbuf_d;
         drop_q   <= drop_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      lane_d     = lane_q;
      psum_d     = psum_q;
      outbuf_d   = outbuf_q;
      drop_d     = 1'b0;
      o_in_ready = 1'b0;
      o_valid    = 1'b0;
      o_data     = '0;
      o_lane     = lane_q;
      o_last     = 1'b0;

      case (state_q)
         IDLE: begin
            o_in_ready = 1'b1;
            if (i_result_valid && !i_clear) begin
               if (i_last_tile) begin
                  outbuf_d = w_fin;
                  psum_d   = '0;
                  lane_d   = '0;
                  state_d  = DRAIN;
               end else begin
                  psum_d   = w_sel;
               end
            end
         end
         DRAIN: begin
            o_valid = 1'b1;
            o_data  = w_out_lane[lane_q];
            o_last  = (lane_q == C_LAST_LANE);
            drop_d  = i_result_valid && !i_clear;
            if (i_ready && !i_clear) begin
               if (lane_q == C_LAST_LANE) begin
                  lane_d  = '0;
                  state_d = IDLE;
               end else begin
                  lane_d  = lane_q + LANE_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Clear overrides any capture or beat in the same cycle
      if (i_clear) begin
         psum_d  = '0;
         lane_d  = '0;
         state_d = IDLE;
      end
   end

   assign o_psum = psum_q;
   assign o_drop = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_psum_collector.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_psum_collector: randomized and directed stimulus against a queue-based model.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_psum_collector;

   localparam int LANES  = 16;
   localparam int DATA_W = 32;
   localparam int S1_W   = 21;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic                    clear, rvalid, last_tile, s2en, ready;
   logic [LANES*S1_W-1:0]   s1;
   logic [LANES*DATA_W-1:0] s2;
   logic                    in_ready, valid, olast, drop;
   logic [LANES*DATA_W-1:0] psum;
   logic [DATA_W-1:0]       data;
   logic [3:0]              lane;

   always #5 clk = ~clk;

   psum_collector #(.LANES(LANES), .DATA_W(DATA_W), .S1_W(S1_W)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_result_valid(rvalid),
      .i_last_tile(last_tile), .i_strategy_2_en(s2en), .i_result_s1(s1),
      .i_result_s2(s2), .o_in_ready(in_ready), .o_psum(psum), .o_valid(valid),
      .o_data(data), .o_lane(lane), .o_last(olast), .i_ready(ready), .o_drop(drop)
   );

   // Model: psum array, queue of beats still to be sent, expected drop pulse
   logic [DATA_W-1:0] m_psum [LANES];
   logic [DATA_W-1:0] m_q [$];
   bit                m_drop;
   int                n_checks = 0;
   int                n_errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] sel_lane(int k);
      logic signed [S1_W-1:0]   t;
      logic signed [DATA_W-1:0] e;
      if (s2en) return s2[k*DATA_W +: DATA_W];
      t = s1[k*S1_W +: S1_W];
      e = t;
      return e;
   endfunction

   function automatic logic [DATA_W-1:0] post(logic [DATA_W-1:0] v);
`ifdef PSUM_COLLECTOR_RELU_EN
      if ($signed(v) < 0) return '0;
`endif
      return v;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < LANES; k++) m_psum[k] = '0;
      m_q.delete();
      m_drop = 0;
   endtask

   task automatic model_step();
      if (clear) begin
         for (int k = 0; k < LANES; k++) m_psum[k] = '0;
         m_q.delete();
         m_drop = 0;
      end else if (m_q.size() != 0) begin
         m_drop = rvalid;
         if (ready) void'(m_q.pop_front());
      end else begin
         m_drop = 0;
         if (rvalid) begin
            for (int k = 0; k < LANES; k++) begin
               if (last_tile) begin
                  m_q.push_back(post(sel_lane(k)));
                  m_psum[k] = '0;
               end else begin
                  m_psum[k] = sel_lane(k);
               end
            end
         end
      end
   endtask

   task automatic check_outputs();
      check("valid", valid, m_q.size() != 0);
      check("in_ready", in_ready, m_q.size() == 0);
      check("drop", drop, m_drop);
      if (m_q.size() != 0) begin
         check("data", data, m_q[0]);
         check("lane", lane, LANES - m_q.size());
         check("last", olast, m_q.size() == 1);
      end else begin
         check("idle_lane", lane, 0);
         check("idle_last", olast, 0);
      end
      for (int k = 0; k < LANES; k++) check($sformatf("psum%0d", k), psum[k*DATA_W +: DATA_W], m_psum[k]);
   endtask

   task automatic step(input bit v, input bit l, input bit se, input bit r, input bit c);
      @(negedge clk);
      check_outputs();
      rvalid = v; last_tile = l; s2en = se; ready = r; clear = c;
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic rand_vectors();
      for (int k = 0; k < LANES; k++) begin
         s2[k*DATA_W +: DATA_W] = $urandom;
         s1[k*S1_W +: S1_W]     = S1_W'($urandom);
      end
   endtask

   initial begin
      int cycles;
      logic [DATA_W-1:0] exp_c;
      rst_n = 1'b0; clear = 0; rvalid = 0; last_tile = 0; s2en = 0; ready = 0;
      s1 = '0; s2 = '0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_valid", valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_data", data, 0);
      check("rst_lane", lane, 0);
      check("rst_last", olast, 0);
      check("rst_drop", drop, 0);
      check("rst_psum", |psum, 0);
      rst_n = 1'b1;

      // Non-final capture of s2 lanes k+1
      for (int k = 0; k < LANES; k++) s2[k*DATA_W +: DATA_W] = DATA_W'(k + 1);
      step(1, 0, 1, 1, 0);
      for (int k = 0; k < LANES; k++) check("nf_psum", psum[k*DATA_W +: DATA_W], k + 1);
      check("nf_valid", valid, 0);

      // Final capture of all-ones s1, drained with ready tied high
      s1 = '1;
`ifdef PSUM_COLLECTOR_RELU_EN
      exp_c = 32'h0;
`else
      exp_c = 32'hFFFF_FFFF;
`endif
      step(1, 1, 0, 1, 0);
      check("fin_psum_zero", |psum, 0);
      cycles = 0;
      for (int b = 0; b < LANES; b++) begin
         check("fin_data", data, exp_c);
         check("fin_lane", lane, b);
         check("fin_last", olast, b == LANES - 1);
         step(0, 0, 0, 1, 0);
         cycles++;
      end
      check("fin_in_ready", in_ready, 1);
      check("fin_cycles", cycles, 16);

      // Backpressure: ready alternates 0,1,0,1...
      rand_vectors();
      step(1, 1, 1, 1, 0);
      cycles = 0;
      for (int c = 0; c < 40; c++) begin
         step(0, 0, 0, c[0], 0);
         cycles++;
         if (in_ready) break;
      end
      check("bp_cycles", cycles, 32);

      // Capture attempt during drain
      rand_vectors();
      step(1, 1, 0, 1, 0);
      step(0, 0, 0, 0, 0);
      rand_vectors();
      step(1, 1, 1, 0, 0);
      check("drop_pulse", drop, 1);
      step(0, 0, 0, 1, 0);
      check("drop_once", drop, 0);
      while (!in_ready) step(0, 0, 0, 1, 0);

      // Clear at lane 7 with a simultaneous capture
      rand_vectors();
      step(1, 0, 1, 1, 0);
      rand_vectors();
      step(1, 1, 1, 1, 0);
      for (int b = 0; b < 7; b++) step(0, 0, 0, 1, 0);
      check("clr_at_lane", lane, 7);
      step(1, 1, 1, 1, 1);
      check("clr_in_ready", in_ready, 1);
      check("clr_valid", valid, 0);
      check("clr_psum", |psum, 0);
      step(0, 0, 0, 1, 0);
      check("clr_no_drop", drop, 0);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         rand_vectors();
         step($urandom_range(0, 9) < 4, $urandom_range(0, 9) < 3, $urandom_range(0, 1),
              $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
      end

      // Async reset in the middle of a drain
      while (!in_ready) step(0, 0, 0, 1, 0);
      rand_vectors();
      step(1, 0, 1, 1, 0);
      rand_vectors();
      step(1, 1, 1, 1, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("arst_valid", valid, 0);
      check("arst_psum", |psum, 0);
      check("arst_in_ready", in_ready, 1);
      model_reset();
      rvalid = 0; clear = 0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 200; i++) begin
         rand_vectors();
         step($urandom_range(0, 9) < 4, $urandom_range(0, 9) < 3, $urandom_range(0, 1),
              $urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0);
      end
      @(negedge clk);
      check_outputs();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
